// File: rtl/uart_pkg.sv
// Shared definitions for the UART APB control slice: register map, bit
// positions, TX sequencer states and frame-width helpers.
package uart_pkg;

  localparam logic [19:0] DEFAULT_BAUD = 20'd16;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_BAUD   = 8'h04;
  localparam logic [7:0] REG_TXDATA = 8'h08;
  localparam logic [7:0] REG_RXDATA = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;

  localparam int CTRL_MODE  = 0;
  localparam int CTRL_TX_EN = 1;
  localparam int CTRL_RX_EN = 2;
  localparam int CTRL_RX_IE = 3;
  localparam int CTRL_TX_IE = 4;

  localparam int ST_TX_PEND = 0;
  localparam int ST_TX_BUSY = 1;
  localparam int ST_RX_FULL = 2;
  localparam int ST_TX_OVF  = 3;
  localparam int ST_RX_OVR  = 4;

  localparam logic MODE_8  = 1'b0;
  localparam logic MODE_10 = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_e;

  // 8-bit frames carry no payload in the top two bits.
  function automatic logic [9:0] frame_mask(input logic mode_v, input logic [9:0] word_v);
    logic [9:0] res_v;
    if (mode_v == MODE_10) begin
      res_v = word_v;
    end else begin
      res_v = {2'b00, word_v[7:0]};
    end
    return res_v;
  endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// TX launch sequencer: one-entry holding register feeding a three-state
// IDLE/START/WAIT handshake with the TX engine.
module uart_tx_seq
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_en,
  input  logic       wr_en,
  input  logic [9:0] wr_data,
  input  logic       tx_done,
  output logic       tx_pend,
  output logic       tx_busy,
  output logic       ovf_set,
  output logic       tx_start,
  output logic [9:0] tx_data
);

  tx_state_e  state_r;
  tx_state_e  state_nxt_s;
  logic       launch_s;
  logic       pend_r;
  logic [9:0] hold_r;
  logic       start_r;
  logic [9:0] data_r;

  // Next-state decode; launch only leaves IDLE, tx_done only matters in WAIT.
  always_comb begin
    state_nxt_s = state_r;
    launch_s    = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (pend_r && tx_en) begin
          state_nxt_s = TX_START;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = TX_IDLE;
        end
      end
      TX_START: state_nxt_s = TX_WAIT;
      TX_WAIT: begin
        if (tx_done) begin
          state_nxt_s = TX_IDLE;
        end else begin
          state_nxt_s = TX_WAIT;
        end
      end
      default: state_nxt_s = TX_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= TX_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Holding register and flopped launch outputs so tx_start cannot glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_r  <= 1'b0;
      hold_r  <= 10'd0;
      start_r <= 1'b0;
      data_r  <= 10'd0;
    end else begin
      if (launch_s) begin
        pend_r <= 1'b0;
      end else if (wr_en) begin
        pend_r <= 1'b1;
      end
      if (wr_en && !pend_r) begin
        hold_r <= wr_data;
      end
      start_r <= launch_s;
      if (launch_s) begin
        data_r <= hold_r;
      end
    end
  end

  assign tx_pend  = pend_r;
  assign tx_busy  = (state_r != TX_IDLE);
  assign ovf_set  = wr_en & pend_r;
  assign tx_start = start_r;
  assign tx_data  = data_r;

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register block for the UART: config shadowing, TX launch through
// uart_tx_seq, one-entry RX buffer, sticky error flags and level interrupt.
module uart_apb_ctrl #(
  parameter logic [19:0] DEFAULT_BAUD = uart_pkg::DEFAULT_BAUD,
  parameter int          ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              mode,
  output logic [19:0]       baud,
  output logic              tx_start,
  output logic [9:0]        tx_data,
  input  logic              tx_done,
  output logic              rx_en,
  input  logic              rx_valid,
  input  logic [9:0]        rx_word,
  output logic              irq
);

  import uart_pkg::*;

  logic        acc_s;
  logic        hit_ctrl_s, hit_baud_s, hit_txdata_s, hit_rxdata_s, hit_status_s;
  logic        unmapped_s;
  logic        wr_ctrl_s, wr_baud_s, wr_txdata_s, wr_status_s, rd_rxdata_s, rd_s;
  logic        mode_r, mode_sh_r, mode_sh_nxt_s;
  logic [19:0] baud_r, baud_sh_r, baud_sh_nxt_s;
  logic        tx_en_r, rx_en_r, rx_ie_r, tx_ie_r;
  logic        rx_full_r, tx_ovf_r, rx_ovr_r;
  logic [9:0]  rx_word_r;
  logic        rx_store_s, rx_ovr_set_s;
  logic        tx_pend_s, tx_busy_s, tx_ovf_set_s;
  logic [31:0] rdata_s;
  logic        unused_pwdata_s;

  assign acc_s        = psel & penable;
  assign hit_ctrl_s   = (paddr == ADDR_W'(REG_CTRL));
  assign hit_baud_s   = (paddr == ADDR_W'(REG_BAUD));
  assign hit_txdata_s = (paddr == ADDR_W'(REG_TXDATA));
  assign hit_rxdata_s = (paddr == ADDR_W'(REG_RXDATA));
  assign hit_status_s = (paddr == ADDR_W'(REG_STATUS));
  assign unmapped_s   = ~(hit_ctrl_s | hit_baud_s | hit_txdata_s | hit_rxdata_s | hit_status_s);

  assign wr_ctrl_s   = acc_s & pwrite & hit_ctrl_s;
  assign wr_baud_s   = acc_s & pwrite & hit_baud_s;
  assign wr_txdata_s = acc_s & pwrite & hit_txdata_s;
  assign wr_status_s = acc_s & pwrite & hit_status_s;
  assign rd_s        = acc_s & ~pwrite;
  assign rd_rxdata_s = rd_s & hit_rxdata_s;

  assign unused_pwdata_s = &{1'b0, pwdata[31:20]};

  // Shadow next values; a zero divisor is never accepted.
  always_comb begin
    mode_sh_nxt_s = mode_sh_r;
    baud_sh_nxt_s = baud_sh_r;
    if (wr_ctrl_s) begin
      mode_sh_nxt_s = pwdata[CTRL_MODE];
    end else begin
      mode_sh_nxt_s = mode_sh_r;
    end
    if (wr_baud_s && (pwdata[19:0] != 20'd0)) begin
      baud_sh_nxt_s = pwdata[19:0];
    end else begin
      baud_sh_nxt_s = baud_sh_r;
    end
  end

  // Config registers; line settings only move while both engines are quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_sh_r <= MODE_8;
      baud_sh_r <= DEFAULT_BAUD;
      mode_r    <= MODE_8;
      baud_r    <= DEFAULT_BAUD;
      tx_en_r   <= 1'b0;
      rx_en_r   <= 1'b0;
      rx_ie_r   <= 1'b0;
      tx_ie_r   <= 1'b0;
    end else begin
      mode_sh_r <= mode_sh_nxt_s;
      baud_sh_r <= baud_sh_nxt_s;
      if (wr_ctrl_s) begin
        tx_en_r <= pwdata[CTRL_TX_EN];
        rx_en_r <= pwdata[CTRL_RX_EN];
        rx_ie_r <= pwdata[CTRL_RX_IE];
        tx_ie_r <= pwdata[CTRL_TX_IE];
      end
      if (!tx_busy_s && !rx_en_r) begin
        mode_r <= mode_sh_nxt_s;
        baud_r <= baud_sh_nxt_s;
      end
    end
  end

  // A read that drains the buffer in the same cycle frees it for the new word.
  assign rx_store_s   = rx_valid & rx_en_r & (~rx_full_r | rd_rxdata_s);
  assign rx_ovr_set_s = rx_valid & rx_en_r & rx_full_r & ~rd_rxdata_s;

  // RX buffer and sticky W1C flags; a new set event wins over the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_full_r <= 1'b0;
      rx_word_r <= 10'd0;
      tx_ovf_r  <= 1'b0;
      rx_ovr_r  <= 1'b0;
    end else begin
      if (rx_store_s) begin
        rx_full_r <= 1'b1;
        rx_word_r <= frame_mask(mode_r, rx_word);
      end else if (rd_rxdata_s) begin
        rx_full_r <= 1'b0;
      end
      tx_ovf_r <= tx_ovf_set_s | (tx_ovf_r & ~(wr_status_s & pwdata[ST_TX_OVF]));
      rx_ovr_r <= rx_ovr_set_s | (rx_ovr_r & ~(wr_status_s & pwdata[ST_RX_OVR]));
    end
  end

  uart_tx_seq u_tx_seq (
    .clk      (clk),
    .rstn     (rstn),
    .tx_en    (tx_en_r),
    .wr_en    (wr_txdata_s),
    .wr_data  (frame_mask(mode_r, pwdata[9:0])),
    .tx_done  (tx_done),
    .tx_pend  (tx_pend_s),
    .tx_busy  (tx_busy_s),
    .ovf_set  (tx_ovf_set_s),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  // Read mux; TXDATA is write-only and reads back zero.
  always_comb begin
    rdata_s = 32'd0;
    case (paddr)
      ADDR_W'(REG_CTRL):   rdata_s = {27'd0, tx_ie_r, rx_ie_r, rx_en_r, tx_en_r, mode_sh_r};
      ADDR_W'(REG_BAUD):   rdata_s = {12'd0, baud_sh_r};
      ADDR_W'(REG_RXDATA): rdata_s = {22'd0, rx_word_r};
      ADDR_W'(REG_STATUS): rdata_s = {27'd0, rx_ovr_r, tx_ovf_r, rx_full_r, tx_busy_s, tx_pend_s};
      default:             rdata_s = 32'd0;
    endcase
  end

  assign prdata  = rd_s ? rdata_s : 32'd0;
  assign pready  = 1'b1;
  assign pslverr = acc_s & unmapped_s;
  assign mode    = mode_r;
  assign baud    = baud_r;
  assign rx_en   = rx_en_r;
  assign irq     = (rx_ie_r & rx_full_r) | (tx_ie_r & ~tx_pend_s & ~tx_busy_s) | tx_ovf_r | rx_ovr_r;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Self-checking bench for uart_apb_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural register model.
module tb_uart_apb_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = 5'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr, mode, tx_start, rx_en, irq;
  logic [19:0] baud;
  logic [9:0]  tx_data;
  logic        tx_done = 1'b0, rx_valid = 1'b0;
  logic [9:0]  rx_word = 10'd0;

  int errs = 0;
  int checks = 0;
  bit rand_mode = 1'b0;

  uart_apb_ctrl #(.DEFAULT_BAUD(20'd16), .ADDR_W(5)) dut (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .mode(mode), .baud(baud), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .rx_en(rx_en), .rx_valid(rx_valid),
    .rx_word(rx_word), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_mode, m_mode_sh, m_tx_en, m_rx_en, m_rx_ie, m_tx_ie;
  logic [19:0] m_baud, m_baud_sh;
  logic        m_pend, m_start, m_inflight;
  logic [9:0]  m_hold, m_tx_data, m_rx_word;
  logic        m_rx_full, m_tx_ovf, m_rx_ovr;

  function automatic logic [9:0] payload(input logic md, input logic [9:0] w);
    return md ? w : (w & 10'h0FF);
  endfunction

  always @(posedge clk or negedge rstn) begin : model
    logic acc, wr, rd, idle, launch, txwr, sw, rxrd, store, ovr;
    logic msh;
    logic [19:0] bsh;
    if (!rstn) begin
      m_mode <= 1'b0; m_mode_sh <= 1'b0; m_tx_en <= 1'b0; m_rx_en <= 1'b0;
      m_rx_ie <= 1'b0; m_tx_ie <= 1'b0; m_baud <= 20'd16; m_baud_sh <= 20'd16;
      m_pend <= 1'b0; m_start <= 1'b0; m_inflight <= 1'b0; m_hold <= 10'd0;
      m_tx_data <= 10'd0; m_rx_word <= 10'd0; m_rx_full <= 1'b0;
      m_tx_ovf <= 1'b0; m_rx_ovr <= 1'b0;
    end else begin
      acc = psel && penable;
      wr = acc && pwrite;
      rd = acc && !pwrite;
      idle = !m_start && !m_inflight;
      msh = (wr && paddr == 5'h00) ? pwdata[0] : m_mode_sh;
      bsh = (wr && paddr == 5'h04 && pwdata[19:0] != 20'd0) ? pwdata[19:0] : m_baud_sh;
      m_mode_sh <= msh;
      m_baud_sh <= bsh;
      if (idle && !m_rx_en) begin
        m_mode <= msh;
        m_baud <= bsh;
      end
      if (wr && paddr == 5'h00) begin
        m_tx_en <= pwdata[1]; m_rx_en <= pwdata[2]; m_rx_ie <= pwdata[3]; m_tx_ie <= pwdata[4];
      end
      launch = idle && m_pend && m_tx_en;
      txwr = wr && paddr == 5'h08;
      if (launch) m_pend <= 1'b0;
      else if (txwr) m_pend <= 1'b1;
      if (txwr && !m_pend) m_hold <= payload(m_mode, pwdata[9:0]);
      if (launch) m_tx_data <= m_hold;
      m_start <= launch;
      if (m_start) m_inflight <= 1'b1;
      else if (m_inflight && tx_done) m_inflight <= 1'b0;
      sw = wr && paddr == 5'h10;
      rxrd = rd && paddr == 5'h0C;
      store = rx_valid && m_rx_en && (!m_rx_full || rxrd);
      ovr = rx_valid && m_rx_en && m_rx_full && !rxrd;
      if (store) begin
        m_rx_full <= 1'b1;
        m_rx_word <= payload(m_mode, rx_word);
      end else if (rxrd) begin
        m_rx_full <= 1'b0;
      end
      m_tx_ovf <= (txwr && m_pend) || (m_tx_ovf && !(sw && pwdata[3]));
      m_rx_ovr <= ovr || (m_rx_ovr && !(sw && pwdata[4]));
    end
  end

  function automatic logic [31:0] exp_prdata();
    logic busy;
    busy = m_start || m_inflight;
    if (!(psel && penable && !pwrite)) return 32'd0;
    case (paddr)
      5'h00: return {27'd0, m_tx_ie, m_rx_ie, m_rx_en, m_tx_en, m_mode_sh};
      5'h04: return {12'd0, m_baud_sh};
      5'h0C: return {22'd0, m_rx_word};
      5'h10: return {27'd0, m_rx_ovr, m_tx_ovf, m_rx_full, busy, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_irq();
    logic busy;
    busy = m_start || m_inflight;
    return (m_rx_ie && m_rx_full) || (m_tx_ie && !m_pend && !busy) || m_tx_ovf || m_rx_ovr;
  endfunction

  function automatic logic exp_slverr();
    return psel && penable && !(paddr inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cmp_prdata", prdata, exp_prdata());
    check("cmp_pslverr", {31'd0, pslverr}, {31'd0, exp_slverr()});
    check("cmp_pready", {31'd0, pready}, 32'd1);
    check("cmp_mode", {31'd0, mode}, {31'd0, m_mode});
    check("cmp_baud", {12'd0, baud}, {12'd0, m_baud});
    check("cmp_tx_start", {31'd0, tx_start}, {31'd0, m_start});
    check("cmp_tx_data", {22'd0, tx_data}, {22'd0, m_tx_data});
    check("cmp_rx_en", {31'd0, rx_en}, {31'd0, m_rx_en});
    check("cmp_irq", {31'd0, irq}, {31'd0, exp_irq()});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_mode) begin
      tx_done  = ($urandom_range(0, 5) == 0);
      rx_valid = ($urandom_range(0, 6) == 0);
      rx_word  = 10'($urandom);
    end else begin
      tx_done  = 1'b0;
      rx_valid = 1'b0;
    end
  endtask

  task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     input logic inj, input logic [9:0] iw,
                     output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    if (inj) begin
      rx_valid = 1'b1;
      rx_word  = iw;
    end
    #1;
    rd  = prdata;
    err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, 1'b0, 10'd0, r, e);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    apb(1'b0, a, 32'd0, 1'b0, 10'd0, r, e);
    check(nm, r, exp);
  endtask

  task automatic wait_start(input string nm, input logic [9:0] exp);
    int n = 0;
    while (!tx_start && n < 10) begin
      tick();
      n++;
    end
    check({nm, "_start"}, {31'd0, tx_start}, 32'd1);
    check({nm, "_data"}, {22'd0, tx_data}, {22'd0, exp});
    tick();
    check({nm, "_one_pulse"}, {31'd0, tx_start}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic e;
    logic [4:0] a;
    logic [31:0] d;
    logic [4:0] addrs [8];
    addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C, 5'h02};

    // reset state
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    tick();
    check("rst_baud", {12'd0, baud}, 32'd16);
    check("rst_model_baud", {12'd0, m_baud}, 32'd16);
    check("rst_mode", {31'd0, mode}, 32'd0);
    check("rst_rx_en", {31'd0, rx_en}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_status", 5'h10, 32'd0);
    rd_chk("rst_baud_rd", 5'h04, 32'd16);

    // mode 1 frame with baud change while idle
    wr(5'h04, 32'd20);
    wr(5'h00, 32'h03);
    check("cfg_baud", {12'd0, baud}, 32'd20);
    check("cfg_mode", {31'd0, mode}, 32'd1);
    wr(5'h08, 32'h30A);
    wait_start("tx1", 10'h30A);
    rd_chk("tx1_busy", 5'h10, 32'h02);
    wr(5'h04, 32'd40);
    check("shadow_baud_hold", {12'd0, baud}, 32'd20);
    rd_chk("shadow_baud_rd", 5'h04, 32'd40);
    tx_done = 1'b1;
    tick();
    check("baud_after_done0", {12'd0, baud}, 32'd20);
    tick();
    check("baud_after_done1", {12'd0, baud}, 32'd40);
    rd_chk("tx1_idle", 5'h10, 32'h00);
    wr(5'h04, 32'd0);
    rd_chk("baud_zero_ignored", 5'h04, 32'd40);
    check("baud_zero_out", {12'd0, baud}, 32'd40);

    // mode 0 masking and holding-register overflow
    wr(5'h00, 32'h00);
    wr(5'h08, 32'h135);
    wr(5'h08, 32'h0AA);
    rd_chk("ovf_status", 5'h10, 32'h09);
    check("ovf_irq", {31'd0, irq}, 32'd1);
    wr(5'h10, 32'h08);
    rd_chk("ovf_w1c", 5'h10, 32'h01);
    wr(5'h00, 32'h02);
    wait_start("tx2", 10'h035);
    tx_done = 1'b1;
    tick();
    check("tx2_data_hold", {22'd0, tx_data}, 32'h035);

    // RX capture, overrun, read-and-capture collision
    wr(5'h00, 32'h0D);
    check("rx_mode", {31'd0, mode}, 32'd1);
    rx_valid = 1'b1; rx_word = 10'h2C3;
    tick();
    check("rx_irq", {31'd0, irq}, 32'd1);
    rd_chk("rx_word1", 5'h0C, 32'h2C3);
    rd_chk("rx_drained", 5'h10, 32'h00);
    rx_valid = 1'b1; rx_word = 10'h111;
    tick();
    rx_valid = 1'b1; rx_word = 10'h222;
    tick();
    rd_chk("rx_ovr_status", 5'h10, 32'h14);
    rd_chk("rx_ovr_keep", 5'h0C, 32'h111);
    wr(5'h10, 32'h10);
    rd_chk("rx_ovr_w1c", 5'h10, 32'h00);
    rx_valid = 1'b1; rx_word = 10'h0AB;
    tick();
    apb(1'b0, 5'h0C, 32'd0, 1'b1, 10'h155, r, e);
    check("rx_collide_old", r, 32'h0AB);
    rd_chk("rx_collide_status", 5'h10, 32'h04);
    rd_chk("rx_collide_new", 5'h0C, 32'h155);

    // unmapped access
    apb(1'b1, 5'h14, 32'hFFFF_FFFF, 1'b0, 10'd0, r, e);
    check("unmapped_wr_err", {31'd0, e}, 32'd1);
    apb(1'b0, 5'h14, 32'd0, 1'b0, 10'd0, r, e);
    check("unmapped_rd_err", {31'd0, e}, 32'd1);
    check("unmapped_rd_data", r, 32'd0);
    rd_chk("unmapped_ctrl_kept", 5'h00, 32'h0D);
    rd_chk("unmapped_status_kept", 5'h10, 32'h00);

    // randomized traffic against the model
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      a = addrs[$urandom_range(0, 7)];
      d = $urandom;
      if (a == 5'h04) d = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
      if ($urandom_range(0, 3) == 0) tick();
      else apb($urandom_range(0, 1) == 1, a, d, 1'b0, 10'd0, r, e);
    end
    rand_mode = 1'b0;

    // reset while a frame is in WAIT
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    wr(5'h00, 32'h02);
    wr(5'h08, 32'h1FF);
    wait_start("tx3", 10'h0FF);
    rstn = 1'b0;
    #1;
    check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    check("midrst_tx_data", {22'd0, tx_data}, 32'd0);
    check("midrst_baud", {12'd0, baud}, 32'd16);
    check("midrst_mode", {31'd0, mode}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_rx_en", {31'd0, rx_en}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    rd_chk("midrst_status", 5'h10, 32'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
